// File: rtl/bcd_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
// Optional BCD_LZB_EN selects leading-zero blanking of latched results.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int          NUM_DIGITS  = 4;
  localparam int          ITER        = 16;
  localparam logic [3:0]  LAST_ITER   = 4'(ITER - 1);
  localparam logic [3:0]  BCD_BLANK   = 4'hF;
  localparam logic [15:0] MAX_VAL_DEF = 16'd9999;

  // Ones digit is never blanked so a zero still shows "0".
  function automatic logic [15:0] bcd_blank(input logic [15:0] d);
    logic [15:0] r;
    logic        seen;
    r    = d;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (!seen && d[i*4 +: 4] == 4'd0) begin
        r[i*4 +: 4] = BCD_BLANK;
      end else begin
        seen = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_convert_scheduler_dabble_step.sv
// One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift
// the 32-bit {bcd, binary} working register left by one.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [31:0] shift_i,
  output logic [31:0] shift_o
);

  logic [31:0] adj;

  always_comb begin
    adj = shift_i;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shift_i[16 + i*4 +: 4] >= 4'd5) begin
        adj[16 + i*4 +: 4] = shift_i[16 + i*4 +: 4] + 4'd3;
      end
    end
    shift_o = adj << 1;
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one bit-serial BCD engine between two
// channels. Define BCD_LZB_EN for leading-zero blanking of the results.
module bcd_convert_scheduler
  import bcd_pkg::*;
#(
  parameter logic [15:0] MAX_VAL = MAX_VAL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] bin0,
  input  logic [15:0] bin1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] bcd0,
  output logic [15:0] bcd1,
  output logic [1:0]  valid,
  output logic [1:0]  ovf
);

  state_t      state_q, state_d;
  logic [1:0]  pending_q, pending_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        clamp_q, clamp_d;
  logic [15:0] bcd0_q, bcd0_d;
  logic [15:0] bcd1_q, bcd1_d;
  logic [1:0]  valid_q, valid_d;
  logic [1:0]  ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;

  logic [1:0]  eligible;
  logic        gnt_id;
  logic [15:0] op;
  logic        clamp;
  logic [15:0] res;
  logic [31:0] step_out;

  bcd_dabble_step u_step (
    .shift_i (shift_q),
    .shift_o (step_out)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | req;
    last_grant_d = last_grant_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    clamp_d      = clamp_q;
    bcd0_d       = bcd0_q;
    bcd1_d       = bcd1_q;
    valid_d      = valid_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    eligible     = pending_q | req;
    gnt_id       = 1'b0;
    op           = bin0;
    clamp        = 1'b0;
`ifdef BCD_LZB_EN
    res          = bcd_blank(shift_q[31:16]);
`else
    res          = shift_q[31:16];
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          unique case (1'b1)
            (eligible == 2'b11): begin
              gnt_id       = ~last_grant_q;
              last_grant_d = ~last_grant_q;
            end
            (eligible == 2'b10): gnt_id = 1'b1;
            (eligible == 2'b01): gnt_id = 1'b0;
            default:             gnt_id = 1'b0;
          endcase
          op    = gnt_id ? bin1 : bin0;
          clamp = op > MAX_VAL;
          shift_d = {16'h0000, clamp ? MAX_VAL : op};
          cnt_d   = 4'd0;
          id_d    = gnt_id;
          clamp_d = clamp;
          // A request on the grant edge itself earns a follow-up conversion.
          pending_d[gnt_id] = req[gnt_id];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_d = step_out;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (id_q) begin
          bcd1_d = res;
        end else begin
          bcd0_d = res;
        end
        valid_d[id_q] = 1'b1;
        ovf_d[id_q]   = clamp_q;
        done_d        = 1'b1;
        done_id_d     = id_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= 2'b00;
      last_grant_q <= 1'b1;
      shift_q      <= 32'h0;
      cnt_q        <= 4'd0;
      id_q         <= 1'b0;
      clamp_q      <= 1'b0;
      bcd0_q       <= 16'h0;
      bcd1_q       <= 16'h0;
      valid_q      <= 2'b00;
      ovf_q        <= 2'b00;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      clamp_q      <= clamp_d;
      bcd0_q       <= bcd0_d;
      bcd1_q       <= bcd1_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
    end
  end

  assign busy    = state_q != ST_IDLE;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd0    = bcd0_q;
  assign bcd1    = bcd1_q;
  assign valid   = valid_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed bench for bcd_convert_scheduler; expected digits follow
// BCD_LZB_EN when it is defined for the build.
module tb_bcd_convert_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] bin0;
  logic [15:0] bin1;
  logic        busy;
  logic        done;
  logic        done_id;
  logic [15:0] bcd0;
  logic [15:0] bcd1;
  logic [1:0]  valid;
  logic [1:0]  ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_convert_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .bin0    (bin0),
    .bin1    (bin1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd0    (bcd0),
    .bcd1    (bcd1),
    .valid   (valid),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] tv_in  [6] = '{16'd0, 16'd9999, 16'd10000,
                              16'd65535, 16'd7, 16'd1050};
  logic [15:0] tv_raw [6] = '{16'h0000, 16'h9999, 16'h9999,
                              16'h9999, 16'h0007, 16'h1050};
  logic [15:0] tv_lzb [6] = '{16'hFFF0, 16'h9999, 16'h9999,
                              16'h9999, 16'hFFF7, 16'h1050};
  logic        tv_ovf [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic logic [15:0] pick(input logic [15:0] raw,
                                       input logic [15:0] lzb);
`ifdef BCD_LZB_EN
    return lzb;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic drain();
    int q;
    q = 0;
    for (int i = 0; i < 300 && q < 2; i++) begin
      tick(1);
      if (!busy && !done) q++;
      else q = 0;
    end
    check("drain", 32'(q), 32'd2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
    check({tag, "_done_id"}, 32'(done_id), 32'd0);
    check({tag, "_bcd0"},    32'(bcd0),    32'd0);
    check({tag, "_bcd1"},    32'(bcd1),    32'd0);
    check({tag, "_valid"},   32'(valid),   32'd0);
    check({tag, "_ovf"},     32'(ovf),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    rst_n = 1'b0;
    req   = 2'b00;
    bin0  = 16'd0;
    bin1  = 16'd0;
    tick(2);
    check_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // single ch0 conversion, exact latency
    bin0 = 16'd1234;
    req  = 2'b01;
    tick(1);
    check("t1_busy", 32'(busy), 32'd1);
    req = 2'b00;
    tick(16);
    check("t1_early_done", 32'(done), 32'd0);
    tick(1);
    check("t1_done",    32'(done),    32'd1);
    check("t1_done_id", 32'(done_id), 32'd0);
    check("t1_bcd0",    32'(bcd0),    32'h1234);
    check("t1_valid",   32'(valid),   32'd1);
    check("t1_bcd1",    32'(bcd1),    32'd0);
    drain();

    // simultaneous requests, ch0 wins first tie
    do_reset();
    bin0 = 16'd42;
    bin1 = 16'd65535;
    req  = 2'b11;
    tick(1);
    req = 2'b00;
    tick(17);
    check("t2_done0",    32'(done),    32'd1);
    check("t2_done_id0", 32'(done_id), 32'd0);
    check("t2_bcd0",     32'(bcd0),    32'(pick(16'h0042, 16'hFF42)));
    tick(18);
    check("t2_done1",    32'(done),    32'd1);
    check("t2_done_id1", 32'(done_id), 32'd1);
    check("t2_bcd1",     32'(bcd1),    32'h9999);
    check("t2_ovf",      32'(ovf),     32'd2);
    check("t2_valid",    32'(valid),   32'd3);
    drain();

    // held requests alternate
    do_reset();
    bin0 = 16'd1;
    bin1 = 16'd2;
    req  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick(18);
      check("t3_done",    32'(done),    32'd1);
      check("t3_done_id", 32'(done_id), 32'(k % 2));
    end
    req = 2'b00;
    drain();

    // operand sampled at grant; follow-up conversion picks up new value
    do_reset();
    bin0 = 16'd5000;
    req  = 2'b01;
    tick(1);
    req = 2'b00;
    tick(4);
    bin0 = 16'd7;
    tick(13);
    check("t4_done", 32'(done), 32'd1);
    check("t4_bcd0", 32'(bcd0), 32'h5000);
    tick(18);
    check("t4_redo_done", 32'(done), 32'd1);
    check("t4_redo_bcd0", 32'(bcd0), 32'(pick(16'h0007, 16'hFFF7)));
    drain();

    // boundary operands on ch0
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bin0 = tv_in[v];
      req  = 2'b01;
      tick(1);
      req = 2'b00;
      tick(17);
      check("tv_done", 32'(done), 32'd1);
      check("tv_bcd0", 32'(bcd0), 32'(pick(tv_raw[v], tv_lzb[v])));
      check("tv_ovf0", 32'(ovf[0]), 32'(tv_ovf[v]));
      drain();
    end

    // reset mid-conversion with ch1 pending
    bin0 = 16'd3;
    req  = 2'b01;
    tick(1);
    req = 2'b10;
    tick(1);
    req = 2'b00;
    tick(7);
    rst_n = 1'b0;
    #1;
    check_zero("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (done) nd++;
    end
    check("t5_no_done", 32'(nd), 32'd0);
    check("t5_idle",    32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
